// File: rtl/mux_arbiter2_pkg.sv
// mux_arbiter2_pkg: shared state encoding and timeout default for the 2-way arbiter
package mux_arbiter2_pkg;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_WAIT  = 2'b10
   } state_t;
   localparam int TIMEOUT_CYC_DEF = 15;
endpackage

// File: rtl/mux_arbiter2_timeout_cnt4.sv
// mux_arbiter2_timeout_cnt4: 4-bit counter of WAIT cycles; clr has priority over en
module mux_arbiter2_timeout_cnt4 (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   output logic [3:0] cnt
);
   logic [3:0] r_cnt;
   always_ff @(posedge clk)
      if (rst || clr) r_cnt <= 4'd0;
      else if (en)    r_cnt <= r_cnt + 4'd1;
   assign cnt = r_cnt;
endmodule

// File: rtl/mux_arbiter2.sv
// mux_arbiter2: round-robin owner of a shared 2-1 mux select, with start/ack handshake
// and a WAIT-cycle timeout that aborts a transaction whose done never arrives.
module mux_arbiter2
   import mux_arbiter2_pkg::*;
#(
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic req0,
   input  logic req1,
   input  logic done,
   output logic sel,
   output logic start,
   output logic gnt0,
   output logic gnt1,
   output logic ack0,
   output logic ack1,
   output logic busy,
   output logic err
);
   state_t     r_state, w_next;
   logic       r_sel, r_last;
   logic       w_sel_nxt, w_last_nxt, w_to, w_fin, w_any;
   logic [3:0] w_cnt;
   mux_arbiter2_timeout_cnt4 u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (r_state == ST_ISSUE),
      .en  (r_state == ST_WAIT),
      .cnt (w_cnt)
   );
   assign w_any      = req0 || req1;
   // done beats a coincident timeout, so err is masked by done
   assign w_to       = (r_state == ST_WAIT) && !done && (w_cnt == 4'(TIMEOUT_CYC - 1));
   assign w_fin      = (r_state == ST_WAIT) && (done || w_to);
   assign w_sel_nxt  = (r_state == ST_IDLE && w_any) ? ((req0 && req1) ? ~r_last : req1) : r_sel;
   assign w_last_nxt = w_fin ? r_sel : r_last;
   always_comb begin
      w_next = ST_IDLE;
      case (r_state)
         ST_IDLE:  w_next = w_any ? ST_ISSUE : ST_IDLE;
         ST_ISSUE: w_next = ST_WAIT;
         ST_WAIT:  w_next = w_fin ? ST_IDLE : ST_WAIT;
         default:  w_next = ST_IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (rst) begin
         r_state <= ST_IDLE;
         r_sel   <= 1'b0;
         r_last  <= 1'b1;
      end else begin
         r_state <= w_next;
         r_sel   <= w_sel_nxt;
         r_last  <= w_last_nxt;
      end
   assign sel   = r_sel;
   assign busy  = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
   assign start = r_state == ST_ISSUE;
   assign gnt0  = busy && !r_sel;
   assign gnt1  = busy && r_sel;
   assign ack0  = (r_state == ST_WAIT) && done && !r_sel;
   assign ack1  = (r_state == ST_WAIT) && done && r_sel;
   assign err   = w_to;
endmodule

// File: tb/tb_mux_arbiter2.sv
// tb_mux_arbiter2: directed vectors feed a queue of expected outputs; a negedge monitor
// pops one entry per cycle. Vector bit order: {sel,start,gnt0,gnt1,ack0,ack1,busy,err}.
module tb_mux_arbiter2;
   typedef struct {
      string      name;
      logic [7:0] v;
   } exp_t;
   logic clk = 1'b0, rst = 1'b1, req0 = 1'b0, req1 = 1'b0, done = 1'b0;
   logic sel, start, gnt0, gnt1, ack0, ack1, busy, err;
   exp_t q[$];
   int   errors = 0, checks = 0;
   mux_arbiter2 #(.TIMEOUT_CYC(15)) dut (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1), .done(done),
      .sel(sel), .start(start), .gnt0(gnt0), .gnt1(gnt1),
      .ack0(ack0), .ack1(ack1), .busy(busy), .err(err)
   );
   always #5 clk = ~clk;
   task automatic step(input string name, input logic r, input logic a, input logic b,
                       input logic d, input logic [7:0] v);
      @(posedge clk);
      #1;
      rst  = r;
      req0 = a;
      req1 = b;
      done = d;
      q.push_back('{name, v});
   endtask
   always @(negedge clk)
      if (q.size() != 0) begin
         exp_t e;
         logic [7:0] act;
         e   = q.pop_front();
         act = {sel, start, gnt0, gnt1, ack0, ack1, busy, err};
         checks++;
         if (act !== e.v) begin
            errors++;
            $display("FAIL %s: got %b expected %b", e.name, act, e.v);
         end
      end
   initial begin
      step("reset1", 1, 0, 0, 0, 8'h00);
      step("reset2", 0, 1, 1, 0, 8'h00);
      // ties from reset alternate 0,1,0,1
      step("tie_iss0a", 0, 1, 1, 0, 8'h62);
      step("tie_wd0a",  0, 1, 1, 1, 8'h2A);
      step("tie_idle0", 0, 1, 1, 0, 8'h00);
      step("tie_iss1a", 0, 1, 1, 0, 8'hD2);
      step("tie_wd1a",  0, 1, 1, 1, 8'h96);
      step("tie_idle1", 0, 1, 1, 0, 8'h80);
      step("tie_iss0b", 0, 1, 1, 0, 8'h62);
      step("tie_wd0b",  0, 1, 1, 1, 8'h2A);
      step("tie_idle2", 0, 1, 1, 0, 8'h00);
      step("tie_iss1b", 0, 1, 1, 0, 8'hD2);
      step("tie_wd1b",  0, 1, 1, 1, 8'h96);
      step("idle_hold", 0, 0, 0, 0, 8'h80);
      // single req0, done two cycles after start
      step("r0_idle",   0, 1, 0, 0, 8'h80);
      step("r0_iss",    0, 1, 0, 0, 8'h62);
      step("r0_wait",   0, 1, 0, 0, 8'h22);
      step("r0_ack",    0, 0, 0, 1, 8'h2A);
      step("r0_back",   0, 1, 0, 0, 8'h00);
      step("r0b_iss",   0, 1, 0, 0, 8'h62);
      step("r0b_ack",   0, 0, 0, 1, 8'h2A);
      step("idle_a",    0, 0, 1, 0, 8'h00);
      // req1 with no done: err on the 15th WAIT cycle
      step("to_iss",    0, 0, 1, 0, 8'hD2);
      for (int i = 0; i < 14; i++) step("to_wait", 0, 0, 1, 0, 8'h92);
      step("to_err",    0, 0, 0, 0, 8'h93);
      step("to_drop",   0, 1, 1, 0, 8'h80);
      step("to_tie0",   0, 1, 1, 0, 8'h62);
      step("to_tie_ack", 0, 0, 1, 1, 8'h2A);
      // reset mid-WAIT with gnt1
      step("rw_idle",   0, 0, 1, 0, 8'h00);
      step("rw_iss",    0, 0, 1, 0, 8'hD2);
      step("rw_wait",   1, 0, 0, 0, 8'h92);
      step("rw_reset",  0, 1, 1, 0, 8'h00);
      step("rw_tie0",   0, 1, 1, 0, 8'h62);
      step("rw_ack0",   0, 0, 0, 1, 8'h2A);
      // done in IDLE and ISSUE ignored
      step("dn_idle",   0, 0, 1, 1, 8'h00);
      step("dn_req1",   0, 0, 1, 1, 8'hD2);
      step("dn_wait",   0, 0, 1, 0, 8'h92);
      step("dn_ack1",   0, 1, 0, 1, 8'h96);
      // done coincides with the timeout cycle: ack wins, no err
      step("dt_idle",   0, 1, 0, 0, 8'h80);
      step("dt_iss",    0, 1, 0, 0, 8'h62);
      for (int i = 0; i < 14; i++) step("dt_wait", 0, 1, 0, 0, 8'h22);
      step("dt_ack",    0, 0, 0, 1, 8'h2A);
      step("dt_idle2",  0, 0, 0, 0, 8'h00);
      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
